// File: rtl/vga_pkg.sv
// Shared VGA and framebuffer definitions.
//   H_ACTIVE/V_ACTIVE/V_TOTAL : display timing of the 640x480 output
//   H_SRC/V_SRC               : geometry of the 320x240 source framebuffer
//   fetch_state_e             : line-fetch sequencer states
//   rgb332_t                  : one framebuffer pixel, {r[2:0], g[2:0], b[1:0]}
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int H_SRC    = 320;
   localparam int V_SRC    = 240;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

endpackage

// File: rtl/line_buffer.sv
// Ping-pong line store: two banks of DEPTH entries, one write port and one
// registered read port. The bank is chosen by a select bit on each port.
//   clk              : clock
//   wr_en/wr_sel     : write strobe and bank for the write port
//   wr_idx/wr_data   : entry index and data to write
//   rd_sel/rd_idx    : bank and entry index for the read port
//   rd_data          : read data, valid one cycle after the address
module line_buffer #(
   parameter int DEPTH  = 320,
   parameter int DATA_W = 8,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_sel,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam int AW = $clog2(2 * DEPTH);

   logic [DATA_W-1:0] mem [0:2*DEPTH-1];
   logic [DATA_W-1:0] rd_data_q;
   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr;

   // Bank 1 occupies the upper DEPTH entries.
   assign wr_addr = wr_sel ? AW'(DEPTH) + AW'(wr_idx) : AW'(wr_idx);
   assign rd_addr = rd_sel ? AW'(DEPTH) + AW'(rd_idx) : AW'(rd_idx);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_reader.sv
// Pixel source for the VGA colour output. Fetches each 320-pixel source line
// from an RGB332 framebuffer into the back half of a ping-pong line buffer,
// and shows the front half with 2x horizontal and 2x vertical replication.
//   clk, rst       : pixel clock, synchronous active-high reset
//   new_line       : one-cycle pulse at the start of each display line
//   v_count        : display line number (valid from the new_line cycle)
//   x_pos, enable  : current active pixel and active-area flag
//   mem_addr/mem_rd: framebuffer read port, data returns one cycle later
//   mem_rdata      : RGB332 pixel read from the framebuffer
//   R, G, B        : expanded 8-bit colour, two cycles after x_pos/enable
//   underrun       : sticky, set when a line trigger finds a fetch still busy
module framebuffer_reader #(
   parameter int H_SRC   = vga_pkg::H_SRC,
   parameter int V_SRC   = vga_pkg::V_SRC,
   parameter int V_TOTAL = vga_pkg::V_TOTAL,
   parameter int ADDR_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              new_line,
   input  logic [9:0]        v_count,
   input  logic [9:0]        x_pos,
   input  logic              enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        R,
   output logic [7:0]        G,
   output logic [7:0]        B,
   output logic              underrun
);

   import vga_pkg::*;

   localparam int                IDX_W     = $clog2(H_SRC);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(H_SRC - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_SRC);

   // Bit replication spreads the short fields over the full 8-bit range,
   // so full-scale codes map to 8'hFF and zero stays zero.
   function automatic logic [23:0] expand_rgb332(input rgb332_t p);
      return {p.r, p.r, p.r[2:1], p.g, p.g, p.g[2:1], {4{p.b}}};
   endfunction

   fetch_state_e      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              front_sel_q, front_sel_d;
   logic              underrun_q, underrun_d;
   logic              wr_en_q, wr_en_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

   logic              en_p1_q, en_p1_d;
   logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
   logic [7:0]        pix_p1;
   logic [IDX_W-1:0]  rd_idx_p0;

   logic              is_wrap, is_even_src, do_fetch, trigger;
   logic              unused_x0;

   assign unused_x0 = x_pos[0];

   // Line trigger decode: the last line of the frame preloads source line 0;
   // each even visible line swaps buffers and prefetches the next source line.
   always_comb begin
      is_wrap     = new_line && (v_count == 10'(V_TOTAL - 1));
      is_even_src = new_line && !v_count[0] && (v_count < 10'(2 * V_SRC));
      do_fetch    = is_wrap || (is_even_src && (v_count[9:1] < 9'(V_SRC - 1)));
      trigger     = is_wrap || is_even_src;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      base_d      = base_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_d    = mem_rd_q;
      front_sel_d = front_sel_q;
      underrun_d  = underrun_q;
      wr_en_d     = mem_rd_q;
      wr_idx_d    = idx_q;

      case (state_q)
         FETCH: begin
            if (idx_q == LAST_IDX) begin
               state_d  = DRAIN;
               mem_rd_d = 1'b0;
            end else begin
               idx_d      = idx_q + IDX_W'(1);
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (trigger) begin
         // A busy fetch is abandoned: its in-flight datum would otherwise land
         // in the bank that is about to become (or already is) the front.
         if (state_q != IDLE) begin
            underrun_d = 1'b1;
            wr_en_d    = 1'b0;
         end
         if (is_even_src) begin
            front_sel_d = ~front_sel_q;
         end
         if (is_wrap) begin
            base_d = '0;
         end else if (do_fetch) begin
            base_d = base_q + LINE_STEP;
         end
         if (do_fetch) begin
            state_d    = FETCH;
            idx_d      = '0;
            mem_rd_d   = 1'b1;
            mem_addr_d = base_d;
         end else begin
            state_d  = IDLE;
            mem_rd_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         base_q      <= '0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         front_sel_q <= 1'b0;
         underrun_q  <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         front_sel_q <= front_sel_d;
         underrun_q  <= underrun_d;
         wr_en_q     <= wr_en_d;
      end
   end

   always_ff @(posedge clk) begin
      wr_idx_q <= wr_idx_d;
   end

   // Stage p0: front-bank read address from x_pos; the right half of the
   // 10-bit range is outside the source line and folds to entry 0.
   always_comb begin
      rd_idx_p0 = (x_pos[9:1] < 9'(H_SRC)) ? IDX_W'(x_pos[9:1]) : '0;
   end

   line_buffer #(
      .DEPTH  (H_SRC),
      .DATA_W (8),
      .IDX_W  (IDX_W)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (wr_en_q),
      .wr_sel  (~front_sel_q),
      .wr_idx  (wr_idx_q),
      .wr_data (mem_rdata),
      .rd_sel  (front_sel_q),
      .rd_idx  (rd_idx_p0),
      .rd_data (pix_p1)
   );

   // Stage p1: expand the buffered pixel, blanked outside the active area.
   always_comb begin
      en_p1_d = enable;
      r_d     = 8'h00;
      g_d     = 8'h00;
      b_d     = 8'h00;
      if (en_p1_q) begin
         {r_d, g_d, b_d} = expand_rgb332(rgb332_t'(pix_p1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_p1_q <= 1'b0;
         r_q     <= 8'h00;
         g_q     <= 8'h00;
         b_q     <= 8'h00;
      end else begin
         en_p1_q <= en_p1_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign underrun = underrun_q;
   assign R        = r_q;
   assign G        = g_q;
   assign B        = b_q;

endmodule
